// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters.
// Latches the winner's transfer, strobes the master, and reports completion or timeout.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_wr_bit,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [7:0]             m_addr,
    output logic [7:0]             m_data,
    output logic                   m_wr_bit,
    output logic                   m_run,
    input  logic                   m_done,
    output logic                   busy
);

    localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_winner;
    logic [15:0]     r_cnt;

    logic [IW-1:0]   w_winner;
    logic [IW-1:0]   w_idx;
    logic            w_any;

    assign w_any = |req;

    // Scan from the farthest slot back to ptr so the slot nearest ptr wins.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_cnt    <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
            m_wr_bit <= 1'b0;
            m_run    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_ISSUE;
                        r_winner <= w_winner;
                        gnt      <= NUM_REQ'(1) << w_winner;
                        m_addr   <= req_addr[{w_winner, 3'b000} +: 8];
                        m_data   <= req_data[{w_winner, 3'b000} +: 8];
                        m_wr_bit <= req_wr_bit[w_winner];
                        m_run    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    m_run   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    // A completion arriving on the last allowed cycle still counts as success.
                    if (m_done) begin
                        r_state <= S_RELEASE;
                        done    <= NUM_REQ'(1) << r_winner;
                        err     <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_RELEASE;
                        done    <= NUM_REQ'(1) << r_winner;
                        err     <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    done    <= '0;
                    err     <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_ptr   <= (r_winner == IW'(NUM_REQ - 1)) ? '0 : r_winner + IW'(1);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: single transfer, round-robin order,
// timeout, done/timeout collision, latch hold and mid-transfer reset.
module tb_i2c_req_arbiter;

    logic        sys_clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_wr_bit;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_wr_bit;
    logic        m_run;
    logic        m_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_req_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_wr_bit (req_wr_bit),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_wr_bit   (m_wr_bit),
        .m_run      (m_run),
        .m_done     (m_done),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m_run) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit         ok;
        int         idx;
        logic [3:0] wr_pat;

        rst        = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        req_wr_bit = '0;
        m_done     = 1'b0;
        #12;
        check("rst_gnt",  gnt,    0);
        check("rst_busy", busy,   0);
        check("rst_run",  m_run,  0);
        check("rst_addr", m_addr, 0);
        check("rst_done", done,   0);
        check("rst_err",  err,    0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_gnt", gnt, 0);

        // single request from requester 0
        req_addr[7:0] = 8'hA0;
        req_data[7:0] = 8'h55;
        req_wr_bit    = 4'b0000;
        req           = 4'b0001;
        tick();
        check("single_gnt",  gnt,      4'b0001);
        check("single_addr", m_addr,   8'hA0);
        check("single_data", m_data,   8'h55);
        check("single_wr",   m_wr_bit, 0);
        check("single_run",  m_run,    1);
        check("single_busy", busy,     1);
        req = 4'b0000;
        tick();
        check("single_run_off", m_run, 0);
        tick();
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("single_done",     done, 4'b0001);
        check("single_err",      err,  0);
        check("single_gnt_rel",  gnt,  4'b0001);
        tick();
        check("single_done_off", done, 0);
        check("single_gnt_off",  gnt,  0);
        check("single_idle",     busy, 0);

        // m_done in IDLE must not do anything
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("stray_mdone_busy", busy, 0);
        check("stray_mdone_done", done, 0);

        // round robin from ptr 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_addr   = {8'h13, 8'h12, 8'h11, 8'h10};
        req_data   = {8'h83, 8'h82, 8'h81, 8'h80};
        wr_pat     = 4'b1010;
        req_wr_bit = wr_pat;
        req        = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            idx = g % 4;
            wait_run(ok);
            check("rr_run_seen", ok, 1);
            check("rr_gnt",  gnt,      32'(4'b0001 << idx));
            check("rr_addr", m_addr,   32'h10 + idx);
            check("rr_data", m_data,   32'h80 + idx);
            check("rr_wr",   m_wr_bit, wr_pat[idx]);
            if (g == 4) req = 4'b0000;
            tick();
            tick();
            tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            check("rr_done", done, 32'(4'b0001 << idx));
            tick();
            check("rr_spacing_run", m_run, 0);
            tick();
        end
        check("rr_end_idle", busy, 0);

        // timeout: ptr is 1, only requester 0 asks
        req = 4'b0001;
        tick();
        check("to_gnt", gnt,   4'b0001);
        check("to_run", m_run, 1);
        req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_wait_done", done, 0);
        end
        tick();
        check("to_done", done, 4'b0001);
        check("to_err",  err,  1);
        tick();
        check("to_err_off", err,  0);
        check("to_idle",    busy, 0);

        // m_done on the last allowed WAIT cycle
        req = 4'b0010;
        tick();
        check("col_gnt", gnt, 4'b0010);
        req = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("col_done", done, 4'b0010);
        check("col_err",  err,  0);
        tick();

        // latched transfer ignores later input changes
        req_addr[23:16] = 8'h3C;
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        tick();
        check("hold_gnt",  gnt,    4'b0100);
        check("hold_addr", m_addr, 8'h3C);
        req = 4'b0000;
        req_addr[23:16] = 8'hFF;
        req_data[23:16] = 8'h00;
        tick();
        tick();
        check("hold_addr_wait", m_addr, 8'h3C);
        check("hold_data_wait", m_data, 8'h5A);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("hold_addr_rel", m_addr, 8'h3C);
        check("hold_done",     done,   4'b0100);
        tick();

        // reset in WAIT drops the transfer and restarts arbitration at ptr 0
        req = 4'b1000;
        tick();
        check("rw_gnt", gnt, 4'b1000);
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rw_async_gnt",  gnt,    0);
        check("rw_async_busy", busy,   0);
        check("rw_async_addr", m_addr, 0);
        check("rw_async_run",  m_run,  0);
        req = 4'b1100;
        tick();
        check("rw_no_done", done, 0);
        check("rw_no_err",  err,  0);
        rst = 1'b0;
        tick();
        check("rw_gnt_after", gnt,    4'b0100);
        check("rw_addr_after", m_addr, 8'hFF);
        req = 4'b0000;
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("rw_done_after", done, 4'b0100);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
